// File: rtl/serial_pattern_detector_pkg.sv
// serial_pattern_detector_pkg: default parameters and fill-width helper for the serial pattern detector
package serial_pattern_detector_pkg;
  localparam int DEF_TICK_DIV_LOG2 = 25;
  localparam int DEF_HISTORY_W = 10;
  localparam int DEF_PATTERN_W = 3;
  localparam int DEF_COUNT_W = 8;
  function automatic int clog2_of(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/serial_pattern_detector_ce_tick_generator.sv
// tick_generator: free-running counter producing a one-cycle clock-enable tick every 2**DIV_LOG2 clocks
module tick_generator #(
  parameter int DIV_LOG2 = 25
) (
  input  logic clock_50_mhz,
  input  logic reset_n,
  output logic tick
);
  logic [DIV_LOG2-1:0] cnt_q, cnt_d;
  // next count simply wraps, so the all-ones phase recurs every 2**DIV_LOG2 clocks
  always_comb cnt_d = cnt_q + 1'b1;
  // counter state; reset restarts the tick phase
  always_ff @(posedge clock_50_mhz or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tick = &cnt_q;
endmodule

// File: rtl/serial_pattern_detector_ce.sv
// serial_pattern_detector_ce: tick-stepped shift history feeding a pattern window with saturating match count
// Build option: define MATCH_STRETCH_EN to hold match until the next step instead of a one-cycle pulse.
module serial_pattern_detector_ce
  import serial_pattern_detector_pkg::*;
#(
  parameter int TICK_DIV_LOG2 = DEF_TICK_DIV_LOG2,
  parameter int HISTORY_W = DEF_HISTORY_W,
  parameter int PATTERN_W = DEF_PATTERN_W,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic                 clock_50_mhz,
  input  logic                 reset_n,
  input  logic                 serial_in,
  input  logic                 shift_en,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic                 overlap_mode,
  input  logic                 clear_count,
  output logic                 tick,
  output logic [HISTORY_W-1:0] history,
  output logic                 match,
  output logic [COUNT_W-1:0]   match_count,
  output logic                 count_sat
);
  localparam int FILL_W = clog2_of(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PATTERN_W);
  localparam logic [HISTORY_W-1:0] HIST_RST = {1'b1, {(HISTORY_W-1){1'b0}}};
  logic step, out_bit, hit;
  logic [HISTORY_W-1:0] history_q, history_d;
  logic [PATTERN_W-1:0] window_q, window_d, window_nx;
  logic [FILL_W-1:0] fill_q, fill_d, fill_nx;
  logic match_q, match_d;
  logic [COUNT_W-1:0] match_count_q, match_count_d;
  logic count_sat_q, count_sat_d;
  tick_generator #(.DIV_LOG2(TICK_DIV_LOG2)) u_tick (
    .clock_50_mhz(clock_50_mhz),
    .reset_n(reset_n),
    .tick(tick)
  );
  assign out_bit = history_q[0];
  if (PATTERN_W == 1) begin : g_win1
    assign window_nx = out_bit;
  end else begin : g_winn
    assign window_nx = {window_q[PATTERN_W-2:0], out_bit};
  end
  // next-state logic: compare is done on the post-step window and fill
  always_comb begin
    step = tick & shift_en;
    fill_nx = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    hit = step & (fill_nx == FULL) & (window_nx == pattern);
    history_d = step ? {serial_in, history_q[HISTORY_W-1:1]} : history_q;
    window_d = step ? window_nx : window_q;
    fill_d = step ? ((hit & ~overlap_mode) ? '0 : fill_nx) : fill_q;
`ifdef MATCH_STRETCH_EN
    match_d = step ? hit : match_q;
`else
    match_d = hit;
`endif
    match_count_d = clear_count ? '0 : (hit & ~&match_count_q) ? match_count_q + 1'b1 : match_count_q;
    count_sat_d = &match_count_d;
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clock_50_mhz or negedge reset_n)
    if (!reset_n) begin
      history_q <= HIST_RST;
      window_q <= '0;
      fill_q <= '0;
      match_q <= 1'b0;
      match_count_q <= '0;
      count_sat_q <= 1'b0;
    end else begin
      history_q <= history_d;
      window_q <= window_d;
      fill_q <= fill_d;
      match_q <= match_d;
      match_count_q <= match_count_d;
      count_sat_q <= count_sat_d;
    end
  assign history = history_q;
  assign match = match_q;
  assign match_count = match_count_q;
  assign count_sat = count_sat_q;
endmodule
